// File: rtl/prog_rom_loader_if.sv
// Write port, core-facing read port and status of the program ROM loader.
// Optional checksum signal exists only when PROG_ROM_CHECKSUM_EN is defined.
interface prog_rom_loader_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          start;
  logic          stop;
  logic [AW-1:0] address;
  logic [DW-1:0] instr;
  logic          cpu_n_reset;
  logic [AW:0]   prog_len;
  logic          busy;
`ifdef PROG_ROM_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  modport master (
    output wr_valid, wr_data, wr_last, start, stop, address,
`ifdef PROG_ROM_CHECKSUM_EN
    input  checksum,
`endif
    input  wr_ready, instr, cpu_n_reset, prog_len, busy
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, start, stop, address,
`ifdef PROG_ROM_CHECKSUM_EN
    output checksum,
`endif
    output wr_ready, instr, cpu_n_reset, prog_len, busy
  );
endinterface

// File: rtl/prog_rom_loader.sv
// Writable 2**AW x DW program memory feeding the CPU core, and owner of the core's reset.
// Define PROG_ROM_CHECKSUM_EN to add a running modulo-2**DW checksum of the loaded bytes.
module prog_rom_loader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             reset,
  prog_rom_loader_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          full_hold_q, full_hold_d;
`ifdef PROG_ROM_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;
`endif

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic wr_ready;
  logic xfer;

  // A full-depth load blocks the port for one cycle so a held-valid source cannot
  // spill a 17th byte into a fresh load.
  assign wr_ready = ((state_q == S_IDLE) && !full_hold_q) || (state_q == S_LOAD);
  assign xfer     = bus.wr_valid && wr_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    clr_ptr_d   = clr_ptr_q;
    prog_len_d  = prog_len_q;
    full_hold_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_wdata   = bus.wr_data;
`ifdef PROG_ROM_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
`ifdef PROG_ROM_CHECKSUM_EN
          checksum_d = bus.wr_data;
`endif
          if (bus.wr_last) begin
            prog_len_d = (AW + 1)'(1);
            wr_ptr_d   = '0;
          end else begin
            wr_ptr_d = AW'(1);
            state_d  = S_LOAD;
          end
        end else if (bus.start) begin
          state_d = S_RUN;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          mem_we = 1'b1;
`ifdef PROG_ROM_CHECKSUM_EN
          checksum_d = checksum_q + bus.wr_data;
`endif
          if (bus.wr_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            prog_len_d  = {1'b0, wr_ptr_q} + (AW + 1)'(1);
            wr_ptr_d    = '0;
            state_d     = S_IDLE;
            full_hold_d = (wr_ptr_q == AW'(DEPTH - 1));
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end

      S_RUN: begin
        if (bus.stop) state_d = S_IDLE;
      end

      default: state_d = S_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      wr_ptr_q    <= '0;
      clr_ptr_q   <= '0;
      prog_len_q  <= '0;
      full_hold_q <= 1'b0;
`ifdef PROG_ROM_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      clr_ptr_q   <= clr_ptr_d;
      prog_len_q  <= prog_len_d;
      full_hold_q <= full_hold_d;
`ifdef PROG_ROM_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // NOTE: the memory array has no reset; the CLEAR sweep zeroes it after every reset instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Asynchronous read: the core's PC-to-ALU path cannot absorb a registered read.
  assign bus.instr       = mem_q[bus.address];
  assign bus.wr_ready    = wr_ready;
  assign bus.cpu_n_reset = (state_q == S_RUN);
  assign bus.busy        = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign bus.prog_len    = prog_len_q;
`ifdef PROG_ROM_CHECKSUM_EN
  assign bus.checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_prog_rom_loader.sv
// Self-checking bench for prog_rom_loader: reference memory model feeds a scoreboard of read expectations.
// Build with PROG_ROM_CHECKSUM_EN defined to also exercise the checksum output.
module tb_prog_rom_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_rom_loader_if #(.AW(4), .DW(8)) bus ();

  prog_rom_loader #(.AW(4), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] model_mem [16];
  logic [3:0] model_ptr;
  logic [7:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_ptr = 4'd0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    model_mem[model_ptr] = d;
    if (l || model_ptr == 4'd15) model_ptr = 4'd0;
    else                         model_ptr = model_ptr + 4'd1;
  endtask

  // Offers one byte and waits (bounded) for the handshake; ok reports whether it transferred.
  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    ok = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = l;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.wr_ready === 1'b1) begin
        ok = 1'b1;
        model_accept(d, l);
        step();
        break;
      end
      step();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  // Drives an address for one cycle, queues the model's expectation and returns the sampled instr.
  task automatic read_cycle(input logic [3:0] a, output logic [7:0] got);
    exp_q.push_back(model_mem[a]);
    bus.address = a;
    #1;
    got = bus.instr;
    step();
  endtask

  task automatic test_reset();
    int cnt;
    bit nrst_bad;
    logic [7:0] got, exp;
    reset = 1'b1;
    step();
    step();
    model_clear();
    total++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else passed++;
    total++; if (bus.cpu_n_reset !== 1'b0) $display("FAIL reset_cpu_n_reset: got %b want 0", bus.cpu_n_reset); else passed++;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); else passed++;
    total++; if (bus.prog_len !== 5'd0) $display("FAIL reset_prog_len: got %0d want 0", bus.prog_len); else passed++;
    reset = 1'b0;
    cnt = 0;
    nrst_bad = 1'b0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      if (bus.cpu_n_reset !== 1'b0 || bus.wr_ready !== 1'b0) nrst_bad = 1'b1;
      cnt++;
      step();
    end
    total++; if (cnt != 16) $display("FAIL clear_busy_cycles: got %0d want 16", cnt); else passed++;
    total++; if (nrst_bad) $display("FAIL clear_outputs: cpu_n_reset/wr_ready got 1 want 0"); else passed++;
    for (int i = 0; i < 16; i++) begin
      read_cycle(4'(i), got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL clear_read[%0d]: got %h want %h", i, got, exp); else passed++;
    end
  endtask

  task automatic test_load_last();
    bit ok;
    logic [7:0] got, exp;
    logic [7:0] bytes [3];
    bytes = '{8'h31, 8'h52, 8'hF0};
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], (i == 2), ok);
      total++; if (!ok) $display("FAIL load_accept[%0d]: got timeout want accepted", i); else passed++;
    end
    #1;
    total++; if (bus.prog_len !== 5'd3) $display("FAIL load_prog_len: got %0d want 3", bus.prog_len); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1)
      $display("FAIL load_back_idle: busy/wr_ready got %b%b want 01", bus.busy, bus.wr_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      read_cycle(4'(i), got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL load_read[%0d]: got %h want %h", i, got, exp); else passed++;
    end
    total++; if (model_mem[2] !== 8'hF0 || model_mem[3] !== 8'h00)
      $display("FAIL load_model: got %h/%h want f0/00", model_mem[2], model_mem[3]); else passed++;
  endtask

  task automatic test_overflow();
    int acc;
    logic [7:0] got, exp;
    logic [3:0] addrs [3];
    acc = 0;
    bus.wr_valid = 1'b1;
    bus.wr_last  = 1'b0;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      bus.wr_data = 8'(acc + 1);
      #1;
      if (bus.wr_ready === 1'b1) begin
        model_accept(8'(acc + 1), 1'b0);
        acc++;
      end
      step();
    end
    bus.wr_data = 8'(acc + 1);
    #1;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL overflow_ready_after_16: got %b want 0", bus.wr_ready); else passed++;
    step();
    bus.wr_valid = 1'b0;
    #1;
    total++; if (acc != 16) $display("FAIL overflow_accepted: got %0d want 16", acc); else passed++;
    total++; if (bus.prog_len !== 5'd16) $display("FAIL overflow_prog_len: got %0d want 16", bus.prog_len); else passed++;
    total++; if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL overflow_idle: wr_ready/busy got %b%b want 10", bus.wr_ready, bus.busy); else passed++;
    addrs = '{4'd15, 4'd0, 4'd7};
    for (int i = 0; i < 3; i++) begin
      read_cycle(addrs[i], got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL overflow_read[%0d]: got %h want %h", addrs[i], got, exp); else passed++;
    end
    total++; if (model_mem[15] !== 8'h10) $display("FAIL overflow_model_top: got %h want 10", model_mem[15]); else passed++;
  endtask

  task automatic test_run();
    logic [7:0] got, exp;
    bus.start = 1'b1;
    #1;
    total++; if (bus.cpu_n_reset !== 1'b0) $display("FAIL run_before_edge: got %b want 0", bus.cpu_n_reset); else passed++;
    step();
    bus.start = 1'b0;
    #1;
    total++; if (bus.cpu_n_reset !== 1'b1) $display("FAIL run_release: got %b want 1", bus.cpu_n_reset); else passed++;
    total++; if (bus.wr_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL run_flags: wr_ready/busy got %b%b want 00", bus.wr_ready, bus.busy); else passed++;
    for (int i = 0; i < 3; i++) begin
      read_cycle(4'(i), got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL run_read[%0d]: got %h want %h", i, got, exp); else passed++;
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    #1;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL run_write_blocked: got %b want 0", bus.wr_ready); else passed++;
    step();
    bus.wr_valid = 1'b0;
    read_cycle(4'd0, got);
    exp = exp_q.pop_front();
    total++; if (got !== exp) $display("FAIL run_mem_untouched: got %h want %h", got, exp); else passed++;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    #1;
    total++; if (bus.cpu_n_reset !== 1'b0) $display("FAIL run_stop_wins: got %b want 0", bus.cpu_n_reset); else passed++;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL run_stop_idle: got %b want 1", bus.wr_ready); else passed++;
  endtask

  task automatic test_priority();
    logic [7:0] got, exp;
    bus.address  = 4'd0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hAA;
    bus.wr_last  = 1'b1;
    bus.start    = 1'b1;
    #1;
    exp = model_mem[0];
    total++; if (bus.instr !== exp) $display("FAIL rdw_old_data: got %h want %h", bus.instr, exp); else passed++;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL prio_ready: got %b want 1", bus.wr_ready); else passed++;
    model_accept(8'hAA, 1'b1);
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.start    = 1'b0;
    #1;
    total++; if (bus.cpu_n_reset !== 1'b0) $display("FAIL prio_start_dropped: got %b want 0", bus.cpu_n_reset); else passed++;
    total++; if (bus.prog_len !== 5'd1) $display("FAIL prio_prog_len: got %0d want 1", bus.prog_len); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL prio_stays_idle: got %b want 0", bus.busy); else passed++;
    for (int i = 0; i < 2; i++) begin
      read_cycle(4'(i), got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL prio_read[%0d]: got %h want %h", i, got, exp); else passed++;
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int cnt;
    logic [7:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h50 + i), 1'b0, ok);
      total++; if (!ok) $display("FAIL midload_accept[%0d]: got timeout want accepted", i); else passed++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    total++; if (bus.prog_len !== 5'd0) $display("FAIL midload_prog_len: got %0d want 0", bus.prog_len); else passed++;
    total++; if (bus.busy !== 1'b1 || bus.cpu_n_reset !== 1'b0)
      $display("FAIL midload_clear: busy/cpu_n_reset got %b%b want 10", bus.busy, bus.cpu_n_reset); else passed++;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    total++; if (cnt != 16) $display("FAIL midload_clear_cycles: got %0d want 16", cnt); else passed++;
    for (int i = 0; i < 16; i++) begin
      read_cycle(4'(i), got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL midload_read[%0d]: got %h want %h", i, got, exp); else passed++;
    end
    send_byte(8'h66, 1'b0, ok);
    total++; if (!ok) $display("FAIL reload_accept0: got timeout want accepted"); else passed++;
    send_byte(8'h77, 1'b1, ok);
    total++; if (!ok) $display("FAIL reload_accept1: got timeout want accepted"); else passed++;
    #1;
    total++; if (bus.prog_len !== 5'd2) $display("FAIL reload_prog_len: got %0d want 2", bus.prog_len); else passed++;
    for (int i = 0; i < 3; i++) begin
      read_cycle(4'(i), got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) $display("FAIL reload_read[%0d]: got %h want %h", i, got, exp); else passed++;
    end
  endtask

`ifdef PROG_ROM_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    send_byte(8'hFF, 1'b0, ok);
    send_byte(8'h02, 1'b1, ok);
    #1;
    total++; if (bus.checksum !== 8'h01) $display("FAIL checksum_wrap: got %h want 01", bus.checksum); else passed++;
    send_byte(8'h10, 1'b0, ok);
    #1;
    total++; if (bus.checksum !== 8'h10) $display("FAIL checksum_restart: got %h want 10", bus.checksum); else passed++;
    send_byte(8'h20, 1'b1, ok);
    #1;
    total++; if (bus.checksum !== 8'h30) $display("FAIL checksum_accum: got %h want 30", bus.checksum); else passed++;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    total++; if (bus.checksum !== 8'h30) $display("FAIL checksum_run_hold: got %h want 30", bus.checksum); else passed++;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask
`endif

  initial begin
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.wr_last  = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.address  = 4'd0;
    model_clear();
    test_reset();
    test_load_last();
    test_overflow();
    test_run();
    test_priority();
    test_reset_mid_load();
`ifdef PROG_ROM_CHECKSUM_EN
    test_checksum();
`endif
    total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
